// File: rtl/operand_fetch_sequencer.sv
// Fetches register and memory operands for one decoded instruction and hands them to execute.
// The data-memory port is shared with writeback through a two-way fair arbiter.
module operand_fetch_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [23:0] instruction,
  output logic        rd_en_reg1,
  output logic [3:0]  reg_id1,
  output logic        rd_en_reg2,
  output logic [3:0]  reg_id2,
  input  logic [15:0] reg_data1,
  input  logic [15:0] reg_data2,
  output logic        rd_en_mem,
  output logic        wr_en_mem,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        wb_req,
  input  logic [15:0] wb_addr,
  output logic        wb_gnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  opcode,
  output logic [1:0]  mode,
  output logic [15:0] op1,
  output logic [15:0] op2
);

  // state    | meaning
  // IDLE     | waiting for an instruction
  // REG      | register file read enables asserted
  // RCAP     | capture register data, branch on mode
  // MEM_REQ  | arbitrate for the data-memory port
  // MEM_WAIT | count down memory latency
  // OUT      | operands presented to execute
  typedef enum logic [2:0] {IDLE, REG, RCAP, MEM_REQ, MEM_WAIT, OUT} state_t;

  state_t      state;
  logic [11:0] imm_q;
  logic        fetch_owed;
  logic [2:0]  lat_cnt;
  logic        fetch_gnt;

  // Writeback gets the port unless fetch is waiting and is either uncontested or owed a turn.
  assign fetch_gnt = !rst && (state == MEM_REQ) && (!wb_req || fetch_owed);
  assign wb_gnt    = !rst && wb_req && !fetch_gnt;
  assign rd_en_mem = fetch_gnt;
  assign wr_en_mem = wb_gnt;

  always_comb begin
    mem_addr = 16'h0000;
    if (fetch_gnt)
      mem_addr = {4'b0000, imm_q};
    else if (wb_gnt)
      mem_addr = wb_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b0;
      rd_en_reg1  <= 1'b0;
      rd_en_reg2  <= 1'b0;
      reg_id1     <= 4'h0;
      reg_id2     <= 4'h0;
      out_valid   <= 1'b0;
      opcode      <= 6'h00;
      mode        <= 2'b00;
      op1         <= 16'h0000;
      op2         <= 16'h0000;
      imm_q       <= 12'h000;
      fetch_owed  <= 1'b0;
      lat_cnt     <= 3'd0;
    end else begin
      rd_en_reg1 <= 1'b0;
      rd_en_reg2 <= 1'b0;
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            instr_ready <= 1'b0;
            opcode      <= instruction[23:18];
            mode        <= instruction[17:16];
            reg_id1     <= instruction[15:12];
            reg_id2     <= instruction[11:8];
            imm_q       <= instruction[11:0];
            rd_en_reg1  <= 1'b1;
            rd_en_reg2  <= (instruction[17:16] == 2'b00);
            state       <= REG;
          end
        end
        REG: state <= RCAP;
        RCAP: begin
          op1 <= reg_data1;
          case (mode)
            2'b00: begin op2 <= reg_data2;            out_valid <= 1'b1; state <= OUT; end
            2'b01: state <= MEM_REQ;
            2'b10: begin op2 <= {4'b0000, imm_q};     out_valid <= 1'b1; state <= OUT; end
            default: begin op2 <= 16'h0000;           out_valid <= 1'b1; state <= OUT; end
          endcase
        end
        MEM_REQ: begin
          if (fetch_gnt) begin
            fetch_owed <= 1'b0;
            lat_cnt    <= 3'(MEM_LAT);
            state      <= MEM_WAIT;
          end else begin
            fetch_owed <= 1'b1;
          end
        end
        MEM_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          // A count of one marks the cycle that holds the read data.
          if (lat_cnt == 3'd1) begin
            op2       <= mem_data;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed plus randomized checks of operand_fetch_sequencer against a behavioural operand model.
module tb_operand_fetch_sequencer;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [23:0] instruction = '0;
  logic        rd_en_reg1, rd_en_reg2;
  logic [3:0]  reg_id1, reg_id2;
  logic [15:0] reg_data1 = '0, reg_data2 = '0;
  logic        rd_en_mem, wr_en_mem;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic        wb_req = 1'b0;
  logic [15:0] wb_addr = 16'h0F00;
  logic        wb_gnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  opcode;
  logic [1:0]  mode;
  logic [15:0] op1, op2;

  operand_fetch_sequencer #(.MEM_LAT(L)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .rd_en_reg1(rd_en_reg1), .reg_id1(reg_id1),
    .rd_en_reg2(rd_en_reg2), .reg_id2(reg_id2), .reg_data1(reg_data1), .reg_data2(reg_data2),
    .rd_en_mem(rd_en_mem), .wr_en_mem(wr_en_mem), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_gnt(wb_gnt), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .mode(mode), .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [16];
  logic [15:0] mem  [4096];
  int vectors = 0;
  int errors  = 0;

  // Register file: data appears only in the cycle after the read enable; garbage otherwise.
  bit       p1 = 0, p2 = 0;
  logic [3:0] i1 = '0, i2 = '0;
  always @(negedge clk) begin
    reg_data1 = p1 ? regs[i1] : 16'($urandom);
    reg_data2 = p2 ? regs[i2] : 16'($urandom);
    p1 = rd_en_reg1; i1 = reg_id1;
    p2 = rd_en_reg2; i2 = reg_id2;
  end

  // Data memory: read data valid exactly L cycles after the rd_en_mem cycle.
  int         pend = 0;
  bit         armed = 0;
  logic [11:0] paddr = '0;
  always @(negedge clk) begin
    if (pend > 0) pend--;
    if (armed && pend == 0) begin
      mem_data = mem[paddr];
      armed = 0;
    end else begin
      mem_data = 16'($urandom);
    end
    if (rd_en_mem === 1'b1) begin
      pend = L; armed = 1; paddr = mem_addr[11:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input logic [23:0] ins, input bit contend, input int stall);
    logic [1:0]  m;
    logic [15:0] e1, e2;
    int          exp_lat, n, k, first_rd;
    bit          reg_bad, both_bad, arb_bad, addr_bad, hold_bad;
    m  = ins[17:16];
    e1 = regs[ins[15:12]];
    case (m)
      2'b00: e2 = regs[ins[11:8]];
      2'b01: e2 = mem[ins[11:0]];
      2'b10: e2 = 16'(ins[11:0]);
      default: e2 = 16'h0000;
    endcase
    exp_lat = (m == 2'b01) ? 4 + L + int'(contend) : 3;
    @(negedge clk);
    wb_req = contend; wb_addr = 16'h0F00 ^ 16'($urandom_range(0, 255));
    out_ready = (stall == 0);
    instruction = ins; instr_valid = 1'b1;
    k = 0;
    while (instr_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0; instruction = 24'($urandom);
    n = 1; first_rd = -1;
    reg_bad = 0; both_bad = 0; arb_bad = 0; addr_bad = 0;
    while (n < 40) begin
      if (rd_en_reg1 !== (n == 1)) reg_bad = 1;
      if (rd_en_reg2 !== (n == 1 && m == 2'b00)) reg_bad = 1;
      if (n == 1 && (reg_id1 !== ins[15:12] || reg_id2 !== ins[11:8])) reg_bad = 1;
      if (rd_en_mem === 1'b1 && wr_en_mem === 1'b1) both_bad = 1;
      if (wr_en_mem !== wb_gnt) both_bad = 1;
      if (contend && ((rd_en_mem ^ wb_gnt) !== 1'b1)) arb_bad = 1;
      if (!contend && wb_gnt !== 1'b0) arb_bad = 1;
      if (rd_en_mem === 1'b1) begin
        if (first_rd < 0) first_rd = n;
        if (mem_addr !== {4'b0000, ins[11:0]}) addr_bad = 1;
      end
      if (wb_gnt === 1'b1 && mem_addr !== wb_addr) addr_bad = 1;
      if (out_valid === 1'b1) break;
      @(negedge clk); n++;
    end
    chk("latency", n, exp_lat);
    chk("op1", op1, e1);
    chk("op2", op2, e2);
    chk("opcode", opcode, ins[23:18]);
    chk("mode", mode, m);
    chk("reg_reads", reg_bad, 0);
    chk("mem_enables", both_bad, 0);
    chk("arbitration", arb_bad, 0);
    chk("mem_addr", addr_bad, 0);
    if (m == 2'b01) chk("rd_mem_cycle", first_rd, contend ? 4 : 3);
    hold_bad = 0;
    repeat (stall) begin
      if (out_valid !== 1'b1 || instr_ready !== 1'b0 || op1 !== e1 || op2 !== e2 ||
          opcode !== ins[23:18] || mode !== m) hold_bad = 1;
      @(negedge clk);
    end
    if (stall > 0) chk("out_hold", hold_bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_handshake", {out_valid, instr_ready}, 2'b01);
    wb_req = 1'b0;
  endtask

  initial begin
    logic [23:0] ins;
    int k;
    bit bad;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    regs[3] = 16'h1111; regs[5] = 16'h2222;

    wb_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {instr_ready, rd_en_reg1, rd_en_reg2, rd_en_mem, wr_en_mem, wb_gnt, out_valid}, 0);
    chk("rst_fields", {opcode, mode, reg_id1, reg_id2}, 0);
    chk("rst_ops", {op1, op2}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    wb_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_instr({6'h2A, 2'b00, 4'd3, 4'd5, 8'h00}, 0, 0);
    run_instr({6'h15, 2'b10, 4'd7, 12'hABC}, 0, 0);
    run_instr({6'h01, 2'b01, 4'd2, 12'h123}, 0, 0);
    run_instr({6'h3F, 2'b01, 4'd9, 12'h456}, 1, 0);
    run_instr({6'h0C, 2'b00, 4'd5, 4'd3, 8'h00}, 0, 5);
    run_instr({6'h21, 2'b11, 4'd1, 12'hFFF}, 1, 2);

    // Reset while waiting on memory.
    @(negedge clk);
    instruction = {6'h11, 2'b01, 4'd4, 12'h321}; instr_valid = 1'b1;
    k = 0;
    while (instr_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (rd_en_mem !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("abort_rd_seen", rd_en_mem, 1);
    @(negedge clk);
    rst = 1'b1; wb_req = 1'b1;
    #1;
    chk("abort_outputs", {instr_ready, rd_en_reg1, rd_en_reg2, rd_en_mem, wr_en_mem, wb_gnt, out_valid}, 0);
    chk("abort_fields", {opcode, mode, reg_id1, reg_id2, mem_addr}, 0);
    chk("abort_ops", {op1, op2}, 0);
    bad = 0;
    repeat (4) begin @(negedge clk); if (out_valid !== 1'b0) bad = 1; end
    rst = 1'b0; wb_req = 1'b0;
    repeat (3) begin @(negedge clk); if (out_valid !== 1'b0) bad = 1; end
    chk("abort_no_valid", bad, 0);
    run_instr({6'h12, 2'b01, 4'd6, 12'h0AA}, 0, 0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
      ins = 24'($urandom);
      run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/operand_fetch_sequencer.md
Name: operand_fetch_sequencer

Overview:
Sequences operand fetch for one decoded 24-bit instruction at a time. It reads the register file, then, for mode 01, reads data memory, and presents opcode/mode/op1/op2 to execute over a valid/ready handshake. The single data-memory port is shared with the writeback stage. A fair two-way arbiter grants that port, so fetch reads and writeback writes never collide. The block sits between instruction fetch and execute and replaces the free-running fetch logic inside decode.

Parameters:
MEM_LAT, 1, cycles from rd_en_mem assertion to mem_data valid (legal range 1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer accepts instruction
instruction  in  24  fields: opcode[23:18], mode[17:16], r1[15:12], r2[11:8], imm/addr[11:0]
rd_en_reg1  out  1  register file port 1 read enable
reg_id1  out  4  port 1 register index
rd_en_reg2  out  1  register file port 2 read enable
reg_id2  out  4  port 2 register index
reg_data1  in  16  port 1 data, valid the cycle after rd_en_reg1
reg_data2  in  16  port 2 data, valid the cycle after rd_en_reg2
rd_en_mem  out  1  data memory read enable
wr_en_mem  out  1  data memory write enable (writeback grant)
mem_addr  out  16  data memory address
mem_data  in  16  memory read data
wb_req  in  1  writeback requests memory port
wb_addr  in  16  writeback write address
wb_gnt  out  1  writeback owns port this cycle (writeback drives write data itself)
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
opcode  out  6  latched opcode
mode  out  2  latched mode
op1  out  16  operand 1
op2  out  16  operand 2

Behaviour:
- Reset (async, any state): state IDLE; instr_ready=0 while rst=1; all enables, wb_gnt, out_valid=0; opcode, mode, op1, op2, reg_id1, reg_id2, mem_addr=0; fetch_owed=0. In-flight operation is abandoned. Late mem_data is ignored.
- States: IDLE, REG, RCAP, MEM_REQ, MEM_WAIT, OUT.
- IDLE: instr_ready=1. When instr_valid=1:
  - latch instruction;
  - reg_id1=r1, reg_id2=r2;
  - go to REG.
- REG (1 cycle):
  - rd_en_reg1=1;
  - rd_en_reg2=1 only if mode=00.
- RCAP (1 cycle): op1<=reg_data1. Then by mode:
  - mode 00: op2<=reg_data2, go to OUT;
  - mode 01: go to MEM_REQ;
  - mode 10: op2<={4'b0000, imm[11:0]}, go to OUT;
  - mode 11: op2<=0, go to OUT.
- MEM_REQ:
  - Fetch wins the port if wb_req=0 or fetch_owed=1. It then drives rd_en_mem=1 and mem_addr={4'b0000, addr[11:0]} for exactly one cycle, clears fetch_owed, loads the counter with MEM_LAT, and goes to MEM_WAIT.
  - Otherwise wb_gnt=1, fetch_owed<=1, and the state stays in MEM_REQ. Fetch therefore waits at most one cycle under continuous wb_req.
- MEM_WAIT: the counter decrements each cycle. The cycle in which mem_data is valid (MEM_LAT cycles after the rd_en_mem cycle) captures op2<=mem_data and goes to OUT.
- Outside MEM_REQ's fetch-grant cycle: wb_gnt=wb_req (combinational), wr_en_mem=wb_gnt, and mem_addr=wb_addr while wb_gnt=1.
- rd_en_mem and wr_en_mem are never both 1.
- OUT: out_valid=1. opcode, mode, op1, op2 stay stable until out_ready=1. The handshake cycle returns to IDLE, so a new instruction can be accepted the following cycle.
- Latency (accept edge = cycle 0), uncontended:
  - modes 00/10/11: out_valid at cycle 3;
  - mode 01: rd_en_mem at cycle 3, out_valid at cycle 4+MEM_LAT.
- wr_en_reg is not driven. Register writes belong to writeback.

Test Plan:
- Mode 00, r1=3 (data 0x1111), r2=5 (data 0x2222) -> rd_en_reg1/2 at cycle 1 with ids 3/5; out_valid cycle 3; op1=0x1111, op2=0x2222.
- Mode 10, imm=0xABC -> rd_en_reg2 never high; op2=0x0ABC; out_valid cycle 3.
- Mode 01, addr=0x123, MEM_LAT=2, no wb_req -> rd_en_mem cycle 3 with mem_addr=0x0123; op2 = mem_data sampled at cycle 5; out_valid cycle 6.
- Mode 01 with wb_req held high (wb_addr=0x0F00) -> cycle 3 wb_gnt=1, wr_en_mem=1, mem_addr=0x0F00; cycle 4 rd_en_mem=1, wb_gnt=0; cycle 5 wb_gnt=1 again; never both enables high.
- out_ready held 0 for 5 cycles in OUT -> outputs stable and instr_ready=0 throughout; accept on release; next instruction accepted one cycle later.
- rst pulsed during MEM_WAIT -> all outputs 0 immediately; no out_valid; the next instruction completes normally.
